// File: rtl/io_handshake_controller_pkg.sv
// Shared types and defaults for the IN/OUT handshake controller.
// State encoding is fixed so that debug probes read the same values across builds.
package io_handshake_controller_pkg;

    localparam int DATA_W_DEFAULT          = 32;
    localparam int SW_W_DEFAULT            = 15;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT_PRESS   = 2'd1,
        ST_WAIT_RELEASE = 2'd2,
        ST_ACK          = 2'd3
    } io_state_t;

    // The stall has to rise in the same cycle as in_req, so IDLE contributes combinationally.
    function automatic logic stall_for(input io_state_t state, input logic in_req);
        return (state == ST_IDLE && in_req) ||
               state == ST_WAIT_PRESS ||
               state == ST_WAIT_RELEASE;
    endfunction

endpackage

// File: rtl/io_handshake_controller_enter_debouncer.sv
// ENTER pushbutton conditioning: 2-FF synchronizer, stability counter and
// single-cycle press/release strobes on the debounced level (1 = released).
module enter_debouncer
    import io_handshake_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic enter,
    output logic press,
    output logic release_pulse
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             enter_meta_reg;
    logic             enter_sync_reg;
    logic             level_reg;
    logic             press_reg;
    logic             release_reg;
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enter_meta_reg <= 1'b1;
            enter_sync_reg <= 1'b1;
            level_reg      <= 1'b1;
            count_reg      <= '0;
            press_reg      <= 1'b0;
            release_reg    <= 1'b0;
        end else begin
            enter_meta_reg <= enter;
            enter_sync_reg <= enter_meta_reg;
            press_reg      <= 1'b0;
            release_reg    <= 1'b0;
            // Any sample matching the current level restarts the stability window.
            if (enter_sync_reg == level_reg) begin
                count_reg <= '0;
            end else if (count_reg == CNT_LAST) begin
                count_reg   <= '0;
                level_reg   <= enter_sync_reg;
                press_reg   <= ~enter_sync_reg;
                release_reg <= enter_sync_reg;
            end else begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    assign press         = press_reg;
    assign release_pulse = release_reg;

endmodule

// File: rtl/io_handshake_controller.sv
// IN/OUT instruction sequencer between the control unit/datapath and the board
// switches, ENTER button and 7-segment display register.
module io_handshake_controller
    import io_handshake_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SW_W            = SW_W_DEFAULT,
    parameter int DATA_W          = DATA_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enter,
    input  logic [SW_W-1:0]   switches,
    input  logic              in_req,
    output logic              in_ack,
    output logic [DATA_W-1:0] in_data,
    output logic              stall,
    input  logic              out_req,
    input  logic [DATA_W-1:0] out_value,
    output logic [DATA_W-1:0] display_value,
    output logic              display_valid,
    output logic              waiting_led
);

    logic              press;
    logic              release_pulse;
    logic [SW_W-1:0]   sw_meta_reg;
    logic [SW_W-1:0]   sw_sync_reg;
    io_state_t         state_reg;
    logic              in_ack_reg;
    logic              waiting_led_reg;
    logic [DATA_W-1:0] in_data_reg;
    logic [DATA_W-1:0] display_value_reg;
    logic              display_valid_reg;

    enter_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter_debouncer (
        .clock         (clock),
        .reset         (reset),
        .enter         (enter),
        .press         (press),
        .release_pulse (release_pulse)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
        end else begin
            sw_meta_reg <= switches;
            sw_sync_reg <= sw_meta_reg;
        end
    end

    // Waiting for release before acking keeps one long press from serving two INs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            in_ack_reg      <= 1'b0;
            waiting_led_reg <= 1'b0;
            in_data_reg     <= '0;
        end else begin
            in_ack_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (in_req) begin
                        state_reg       <= ST_WAIT_PRESS;
                        waiting_led_reg <= 1'b1;
                    end
                end
                ST_WAIT_PRESS: begin
                    if (!in_req) begin
                        state_reg       <= ST_IDLE;
                        waiting_led_reg <= 1'b0;
                    end else if (press) begin
                        in_data_reg     <= DATA_W'(sw_sync_reg);
                        state_reg       <= ST_WAIT_RELEASE;
                        waiting_led_reg <= 1'b0;
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (!in_req) begin
                        state_reg <= ST_IDLE;
                    end else if (release_pulse) begin
                        state_reg  <= ST_ACK;
                        in_ack_reg <= 1'b1;
                    end
                end
                ST_ACK: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg       <= ST_IDLE;
                    waiting_led_reg <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            display_value_reg <= '0;
            display_valid_reg <= 1'b0;
        end else if (out_req) begin
            display_value_reg <= out_value;
            display_valid_reg <= 1'b1;
        end
    end

    assign stall         = stall_for(state_reg, in_req);
    assign in_ack        = in_ack_reg;
    assign in_data       = in_data_reg;
    assign waiting_led   = waiting_led_reg;
    assign display_value = display_value_reg;
    assign display_valid = display_valid_reg;

endmodule

// File: tb/tb_io_handshake_controller.sv
// Self-checking bench for io_handshake_controller with a short debounce window.
// A behavioural model tracks raw input history and the handshake rules.
module tb_io_handshake_controller;

    localparam int DB     = 4;
    localparam int SW_W   = 15;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              enter = 1'b1;
    logic [SW_W-1:0]   switches = '0;
    logic              in_req = 1'b0;
    logic              out_req = 1'b0;
    logic [DATA_W-1:0] out_value = '0;
    logic              in_ack;
    logic [DATA_W-1:0] in_data;
    logic              stall;
    logic [DATA_W-1:0] display_value;
    logic              display_valid;
    logic              waiting_led;

    int errors = 0;
    int checks = 0;

    io_handshake_controller #(
        .DEBOUNCE_CYCLES(DB),
        .SW_W           (SW_W),
        .DATA_W         (DATA_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enter         (enter),
        .switches      (switches),
        .in_req        (in_req),
        .in_ack        (in_ack),
        .in_data       (in_data),
        .stall         (stall),
        .out_req       (out_req),
        .out_value     (out_value),
        .display_value (display_value),
        .display_valid (display_valid),
        .waiting_led   (waiting_led)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural reference model ----------------
    typedef enum int {M_IDLE, M_WP, M_WR, M_ACK} m_state_t;

    logic [15:0]       raw_hist;
    logic [SW_W-1:0]   sw_hist0, sw_hist1;
    logic              m_level, m_press, m_rel;
    m_state_t          m_state;
    logic [DATA_W-1:0] m_data, m_disp;
    logic              m_dvalid;

    // True when the last DB synchronised samples all disagree with the debounced level.
    function automatic bit window_differs(input logic [15:0] h, input logic lvl);
        for (int i = 1; i <= DB; i++) if (h[i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            raw_hist <= '1;
            sw_hist0 <= '0;
            sw_hist1 <= '0;
            m_level  <= 1'b1;
            m_press  <= 1'b0;
            m_rel    <= 1'b0;
            m_state  <= M_IDLE;
            m_data   <= '0;
            m_disp   <= '0;
            m_dvalid <= 1'b0;
        end else begin
            raw_hist <= {raw_hist[14:0], enter};
            sw_hist0 <= switches;
            sw_hist1 <= sw_hist0;
            if (window_differs(raw_hist, m_level)) begin
                m_level <= ~m_level;
                m_press <= m_level;
                m_rel   <= ~m_level;
            end else begin
                m_press <= 1'b0;
                m_rel   <= 1'b0;
            end
            case (m_state)
                M_IDLE: if (in_req) m_state <= M_WP;
                M_WP: begin
                    if (!in_req) m_state <= M_IDLE;
                    else if (m_press) begin
                        m_data  <= 32'(sw_hist1);
                        m_state <= M_WR;
                    end
                end
                M_WR: begin
                    if (!in_req) m_state <= M_IDLE;
                    else if (m_rel) m_state <= M_ACK;
                end
                default: m_state <= M_IDLE;
            endcase
            if (out_req) begin
                m_disp   <= out_value;
                m_dvalid <= 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_ack(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (in_ack === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic wait_leave_waiting(input int budget, output bit done);
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (waiting_led === 1'b0) done = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; enter = 1'b0; switches = 15'h7FFF; in_req = 1'b0; out_req = 1'b0;
        repeat (3) tick();
        checks++;
        if ({in_ack, stall, waiting_led, display_valid, in_data, display_value} !== '0) begin
            errors++;
            $display("FAIL reset_hold: got ack=%b stall=%b wait=%b dv=%b data=%h disp=%h want all 0",
                     in_ack, stall, waiting_led, display_valid, in_data, display_value);
        end
        reset = 1'b1;
        repeat (10) tick();
        checks++;
        if ({in_ack, stall, waiting_led, display_valid, in_data, display_value} !== '0) begin
            errors++;
            $display("FAIL reset_release: got ack=%b stall=%b wait=%b dv=%b data=%h disp=%h want all 0",
                     in_ack, stall, waiting_led, display_valid, in_data, display_value);
        end
        enter = 1'b1;
        repeat (12) tick();
        $display("test_reset done");
    endtask

    task automatic test_basic_in();
        bit seen;
        bit stall_ok = 1'b1;
        switches = 15'h1234;
        repeat (3) tick();
        in_req = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL basic_stall_same_cycle: got %b want 1", stall);
        end
        tick();
        checks++;
        if (waiting_led !== 1'b1) begin
            errors++;
            $display("FAIL basic_waiting_led: got %b want 1", waiting_led);
        end
        enter = 1'b0;
        repeat (6) begin
            tick();
            if (stall !== 1'b1 || in_ack !== 1'b0) stall_ok = 1'b0;
        end
        enter = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (in_ack === 1'b1) seen = 1'b1;
            else if (stall !== 1'b1) stall_ok = 1'b0;
        end
        checks++;
        if (!stall_ok) begin
            errors++;
            $display("FAIL basic_stall_held: got stall dropped or early ack, want stall=1 until ack");
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL basic_ack_timeout: got no ack in 20 cycles want ack");
        end
        checks++;
        if (in_data !== 32'h0000_1234 || stall !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack_data: got data=%h stall=%b want data=00001234 stall=0", in_data, stall);
        end
        in_req = 1'b0;
        tick();
        checks++;
        if (in_ack !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack_width: got ack=%b stall=%b want ack=0 stall=0", in_ack, stall);
        end
        $display("test_basic_in: ack in_data=%h", in_data);
    endtask

    task automatic test_bounce();
        bit seen, done;
        bit led_ok = 1'b1;
        logic [SW_W-1:0] sw = SW_W'($urandom);
        switches = sw;
        in_req = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 10; i++) begin
            enter = ~enter;
            repeat (2) begin
                tick();
                if (waiting_led !== 1'b1) led_ok = 1'b0;
            end
        end
        checks++;
        if (!led_ok) begin
            errors++;
            $display("FAIL bounce_no_press: got waiting_led dropped want waiting_led=1 throughout");
        end
        enter = 1'b0;
        repeat (5) tick();
        enter = 1'b1;
        wait_leave_waiting(10, done);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL bounce_clean_press: got still waiting want press accepted");
        end
        wait_ack(20, seen);
        checks++;
        if (!seen || in_data !== 32'(sw)) begin
            errors++;
            $display("FAIL bounce_ack: got seen=%b data=%h want seen=1 data=%h", seen, in_data, 32'(sw));
        end
        in_req = 1'b0;
        tick();
        $display("test_bounce: ack in_data=%h", in_data);
    endtask

    task automatic test_held();
        bit seen, done;
        int acks = 0;
        bit ok = 1'b1;
        in_req = 1'b1;
        tick();
        enter = 1'b0;
        wait_leave_waiting(12, done);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL held_first_press: got still waiting want press accepted");
        end
        repeat (20) begin
            tick();
            if (in_ack !== 1'b0 || stall !== 1'b1) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL held_no_early_ack: got ack or no stall while held want stall=1 ack=0");
        end
        enter = 1'b1;
        wait_ack(20, seen);
        if (seen) acks++;
        in_req = 1'b0;
        tick();
        enter = 1'b0;
        repeat (10) tick();
        in_req = 1'b1;
        ok = 1'b1;
        repeat (20) begin
            tick();
            if (waiting_led !== 1'b1 || in_ack !== 1'b0) ok = 1'b0;
        end
        enter = 1'b1;
        repeat (10) tick();
        if (waiting_led !== 1'b1) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL held_second_waits: got progress on stale press want waiting_led=1 ack=0");
        end
        enter = 1'b0;
        repeat (8) tick();
        enter = 1'b1;
        wait_ack(20, seen);
        if (seen) acks++;
        checks++;
        if (acks != 2) begin
            errors++;
            $display("FAIL held_ack_count: got %0d acks want 2", acks);
        end
        in_req = 1'b0;
        tick();
        $display("test_held: acks=%0d", acks);
    endtask

    task automatic test_abort();
        bit done;
        bit no_ack = 1'b1;
        logic [SW_W-1:0] sw = SW_W'($urandom);
        switches = sw;
        repeat (3) tick();
        in_req = 1'b1;
        tick();
        enter = 1'b0;
        wait_leave_waiting(12, done);
        checks++;
        if (!done || in_data !== 32'(sw)) begin
            errors++;
            $display("FAIL abort_latch: got done=%b data=%h want done=1 data=%h", done, in_data, 32'(sw));
        end
        in_req = 1'b0;
        tick();
        checks++;
        if (stall !== 1'b0 || waiting_led !== 1'b0 || in_ack !== 1'b0 || in_data !== 32'(sw)) begin
            errors++;
            $display("FAIL abort_idle: got stall=%b wait=%b ack=%b data=%h want 0 0 0 %h",
                     stall, waiting_led, in_ack, in_data, 32'(sw));
        end
        switches = ~sw;
        enter = 1'b1;
        repeat (15) begin
            tick();
            if (in_ack !== 1'b0) no_ack = 1'b0;
        end
        checks++;
        if (!no_ack || in_data !== 32'(sw)) begin
            errors++;
            $display("FAIL abort_no_ack: got ack_seen=%b data=%h want no ack data=%h", !no_ack, in_data, 32'(sw));
        end
        $display("test_abort: in_data kept %h", in_data);
    endtask

    task automatic test_out();
        bit seen;
        switches = 15'h0ABC;
        in_req = 1'b1;
        tick();
        checks++;
        if (display_valid !== 1'b0) begin
            errors++;
            $display("FAIL out_valid_before: got %b want 0", display_valid);
        end
        out_value = 32'hDEAD_BEEF;
        out_req = 1'b1;
        tick();
        out_req = 1'b0;
        out_value = 32'h0;
        checks++;
        if (display_value !== 32'hDEAD_BEEF || display_valid !== 1'b1 ||
            waiting_led !== 1'b1 || stall !== 1'b1) begin
            errors++;
            $display("FAIL out_capture: got disp=%h dv=%b wait=%b stall=%b want deadbeef 1 1 1",
                     display_value, display_valid, waiting_led, stall);
        end
        enter = 1'b0;
        repeat (6) tick();
        enter = 1'b1;
        wait_ack(20, seen);
        checks++;
        if (!seen || in_data !== 32'h0000_0ABC || display_value !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL out_in_unaffected: got seen=%b data=%h disp=%h want 1 00000abc deadbeef",
                     seen, in_data, display_value);
        end
        in_req = 1'b0;
        tick();
        $display("test_out: display_value=%h", display_value);
    endtask

    task automatic test_random();
        int run_left = 0;
        logic exp_stall;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (in_ack === 1'b1 && $urandom_range(0, 3) != 0) in_req = 1'b0;
            else if ($urandom_range(0, 39) == 0) in_req = ~in_req;
            if (run_left == 0) begin
                enter = ~enter;
                run_left = $urandom_range(1, 12);
            end
            run_left--;
            if ($urandom_range(0, 49) == 0) switches = SW_W'($urandom);
            out_req = ($urandom_range(0, 7) == 0);
            out_value = $urandom;
            if (cyc == 1500) reset = 1'b0;
            else reset = 1'b1;
            tick();
            exp_stall = (m_state == M_IDLE && in_req) || m_state == M_WP || m_state == M_WR;
            checks++;
            if ({in_ack, stall, waiting_led, display_valid, in_data, display_value} !==
                {m_state == M_ACK, exp_stall, m_state == M_WP, m_dvalid, m_data, m_disp}) begin
                errors++;
                $display("FAIL random_cycle_%0d: got ack=%b stall=%b wait=%b dv=%b data=%h disp=%h want ack=%b stall=%b wait=%b dv=%b data=%h disp=%h",
                         cyc, in_ack, stall, waiting_led, display_valid, in_data, display_value,
                         m_state == M_ACK, exp_stall, m_state == M_WP, m_dvalid, m_data, m_disp);
            end
            if (in_ack === 1'b1) $display("random ack cycle=%0d in_data=%h", cyc, in_data);
        end
        reset = 1'b1;
        out_req = 1'b0;
        in_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_in();
        test_bounce();
        test_held();
        test_abort();
        test_out();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
